// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared ID/EX pipeline definitions: ALUop encodings, EX control bundle, default widths.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package id_ex_pipe_reg_pkg;

  // Default datapath and index widths
  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  // ALU operation classes produced by the decode control unit
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  // Control bundle consumed by EX (and carried onward to MEM/WB)
  typedef struct packed {
    logic [1:0] ALUop;
    logic       ALUSrc;
    logic       branch;
    logic       jump;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regWrite;
  } ctrl_ex_t;

  localparam ctrl_ex_t CTRL_NOP = '0;

  // Suppress every side-effecting control bit when the slot is not a real
  // instruction. ALUop/ALUSrc/memToReg are harmless and pass through as given.
  function automatic ctrl_ex_t gate_bubble(input ctrl_ex_t c, input logic vld);
    ctrl_ex_t g;
    g = c;
    if (!vld) begin
      g.regWrite = 1'b0;
      g.memWrite = 1'b0;
      g.memRead  = 1'b0;
      g.branch   = 1'b0;
      g.jump     = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// pipe_sat_counter: CNT_W-bit up counter that sticks at all-ones.
// Latency: count visible the cycle after an enabled edge.
// Backpressure: none; i_en is sampled every edge, async active-low clear.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {CNT_W{1'b1}});

  // Count enabled edges, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: control bundle, operands, PC, immediate, indices and valid bit.
// Latency: 1 cycle; priority per edge is flush (bubble) > stall (hold) > load.
// Backpressure: stall freezes every output; optional perf counters under IDEX_PERF_CNT_EN.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
`ifdef IDEX_PERF_CNT_EN
  ,
  parameter int CNT_W  = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [1:0]        ALUop_in,
  input  logic              ALUSrc_in,
  input  logic              branch_in,
  input  logic              jump_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              memToReg_in,
  input  logic              regWrite_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [REG_AW-1:0] rs1_in,
  input  logic [REG_AW-1:0] rs2_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [3:0]        funct_in,
  output logic              valid_out,
  output logic [1:0]        ALUop_out,
  output logic              ALUSrc_out,
  output logic              branch_out,
  output logic              jump_out,
  output logic              memRead_out,
  output logic              memWrite_out,
  output logic              memToReg_out,
  output logic              regWrite_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rs1_data_out,
  output logic [XLEN-1:0]   rs2_data_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [REG_AW-1:0] rs1_out,
  output logic [REG_AW-1:0] rs2_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [3:0]        funct_out
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  ctrl_ex_t          w_ctrl_in;
  ctrl_ex_t          w_ctrl_gated;
  logic              w_load;
  logic              w_valid_next;

  ctrl_ex_t          r_ctrl;
  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [3:0]        r_funct;

  assign w_ctrl_in = '{
    ALUop:    ALUop_in,
    ALUSrc:   ALUSrc_in,
    branch:   branch_in,
    jump:     jump_in,
    memRead:  memRead_in,
    memWrite: memWrite_in,
    memToReg: memToReg_in,
    regWrite: regWrite_in
  };

  // Only an explicit valid_in=1 counts as a real instruction, so an unknown
  // valid_in resolves to a bubble and never lets side-effect bits through.
  assign w_valid_next = (valid_in === 1'b1);
  assign w_ctrl_gated = gate_bubble(w_ctrl_in, w_valid_next);
  assign w_load       = !flush && !stall;

  // Control bundle and valid bit: flush inserts a clean bubble, stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= CTRL_NOP;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_ctrl  <= CTRL_NOP;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_ctrl  <= w_ctrl_gated;
      r_valid <= w_valid_next;
    end
  end

  // Datapath fields: zeroed on flush so bubbles are bit-for-bit deterministic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
    end else if (flush) begin
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
    end else if (w_load) begin
      r_pc       <= pc_in;
      r_rs1_data <= rs1_data_in;
      r_rs2_data <= rs2_data_in;
      r_imm      <= imm_in;
      r_rs1      <= rs1_in;
      r_rs2      <= rs2_in;
      r_rd       <= rd_in;
      r_funct    <= funct_in;
    end
  end

  assign valid_out    = r_valid;
  assign ALUop_out    = r_ctrl.ALUop;
  assign ALUSrc_out   = r_ctrl.ALUSrc;
  assign branch_out   = r_ctrl.branch;
  assign jump_out     = r_ctrl.jump;
  assign memRead_out  = r_ctrl.memRead;
  assign memWrite_out = r_ctrl.memWrite;
  assign memToReg_out = r_ctrl.memToReg;
  assign regWrite_out = r_ctrl.regWrite;
  assign pc_out       = r_pc;
  assign rs1_data_out = r_rs1_data;
  assign rs2_data_out = r_rs2_data;
  assign imm_out      = r_imm;
  assign rs1_out      = r_rs1;
  assign rs2_out      = r_rs2;
  assign rd_out       = r_rd;
  assign funct_out    = r_funct;

`ifdef IDEX_PERF_CNT_EN
  logic w_bubble_evt;

  // A bubble lands on a flush edge or on a non-stalled load of an empty slot
  assign w_bubble_evt = flush || (w_load && !w_valid_next);

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_bubble_evt),
    .o_cnt (bubble_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (flush),
    .o_cnt (flush_cnt)
  );
`endif

endmodule
